// File: rtl/sync_dual_port_sram_param.sv
// Simple dual-port synchronous SRAM with lane write enables, selectable
// read-during-write policy and a sequenced post-reset clear sweep.
module sync_dual_port_sram_param #(
  parameter int              DATA_W   = 16,
  parameter int              LANE_W   = 8,
  parameter int              ADDR_W   = 4,
  parameter int              RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int             NLANES   = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [NLANES-1:0] w_be,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_old, rd_word;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic                r_valid_q, r_valid_d;
  logic                rdy;

  assign rdy = (state_q == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + ADDR_W'(1);
      if (clr_q == LAST_ADDR) state_d = READY;
    end
  end

  // Storage has no reset so it can map onto a macro; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!rdy) begin
        mem_q[clr_q] <= INIT_VAL;
      end else if (we) begin
        for (int k = 0; k < NLANES; k++)
          if (w_be[k]) mem_q[w_addr][k*LANE_W +: LANE_W] <= w_data[k*LANE_W +: LANE_W];
      end
    end
  end

  assign rd_old = mem_q[r_addr];

  generate
    if (RDW_MODE == 1) begin : g_new
      logic hit;
      assign hit = we && (w_addr == r_addr);
      for (genvar k = 0; k < NLANES; k++) begin : g_lane
        assign rd_word[k*LANE_W +: LANE_W] = (hit && w_be[k]) ? w_data[k*LANE_W +: LANE_W]
                                                             : rd_old[k*LANE_W +: LANE_W];
      end
    end else begin : g_old
      assign rd_word = rd_old;
    end
  endgenerate

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    if (rdy && re) begin
      r_data_d  = rd_word;
      r_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
  assign init_busy = !rdy;

endmodule

// File: tb/tb_sync_dual_port_sram_param.sv
// Randomized + directed bench: two instances (old-data and new-data
// read-during-write) driven identically, checked against an array model.
module tb_sync_dual_port_sram_param;
  localparam int DW = 16, LW = 8, AW = 4, NL = DW / LW, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, we, re;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic [NL-1:0] w_be;
  logic [DW-1:0] r_data0, r_data1;
  logic          r_valid0, r_valid1, busy0, busy1;

  int total = 0, bad = 0;

  // model state
  logic [DW-1:0] mm [DEPTH];
  int            clr_left = DEPTH;
  logic [DW-1:0] ed0 = '0, ed1 = '0;
  logic          ev = 1'b0;

  always #5 clk = ~clk;

  sync_dual_port_sram_param #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW), .RDW_MODE(0), .INIT_VAL('0)) u_old (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .re(re), .r_addr(r_addr), .r_data(r_data0), .r_valid(r_valid0), .init_busy(busy0));

  sync_dual_port_sram_param #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW), .RDW_MODE(1), .INIT_VAL('0)) u_new (
    .clk(clk), .rst(rst), .we(we), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .re(re), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1), .init_busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NL-1:0] be);
    logic [DW-1:0] r = old;
    for (int k = 0; k < NL; k++)
      if (be[k]) r[k*LW +: LW] = nw[k*LW +: LW];
    return r;
  endfunction

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic r, input logic w, input int wa, input logic [DW-1:0] wd,
                      input logic [NL-1:0] be, input logic rd, input int ra);
    rst = r; we = w; w_addr = AW'(wa); w_data = wd; w_be = be; re = rd; r_addr = AW'(ra);
    @(posedge clk);
    #1;
    if (r) begin
      clr_left = DEPTH; ev = 1'b0; ed0 = '0; ed1 = '0;
    end else if (clr_left > 0) begin
      ev = 1'b0;
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    end else begin
      ev = rd;
      if (rd) begin
        ed0 = mm[ra];
        ed1 = (w && wa == ra) ? merge(mm[ra], wd, be) : mm[ra];
      end
      if (w) mm[wa] = merge(mm[wa], wd, be);
    end
    chk("valid_old", {31'b0, r_valid0}, {31'b0, ev});
    chk("valid_new", {31'b0, r_valid1}, {31'b0, ev});
    chk("rdata_old", {16'b0, r_data0}, {16'b0, ed0});
    chk("rdata_new", {16'b0, r_data1}, {16'b0, ed1});
    chk("busy_old", {31'b0, busy0}, {31'b0, clr_left > 0});
    chk("busy_new", {31'b0, busy1}, {31'b0, clr_left > 0});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    step(1'b0, 1'b1, a, d, be, 1'b0, 0);
  endtask

  task automatic rdq(input int a);
    step(1'b0, 1'b0, 0, '0, '0, 1'b1, a);
  endtask

  initial begin
    // reset 2 cycles, then sweep with writes/reads that must be ignored
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    step(1'b1, 1'b0, 0, '0, '0, 1'b1, 0);
    chk("reset_rdata", {16'b0, r_data0}, 32'h0);
    chk("reset_busy", {31'b0, busy0}, 32'h1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 0, 16'hFFFF, 2'b11, 1'b1, 0);
    chk("busy_fell", {31'b0, busy0}, 32'h0);
    for (int i = 0; i < DEPTH; i++) rdq(i);
    idle();

    // basic write/read and lane enables
    wr(3, 16'hA5C3, 2'b11);
    rdq(3);
    chk("basic", {16'b0, r_data0}, 32'hA5C3);
    idle();
    wr(3, 16'h1234, 2'b01);
    rdq(3);
    chk("be01", {16'b0, r_data0}, 32'hA534);
    wr(3, 16'hFFFF, 2'b00);
    rdq(3);
    chk("be00", {16'b0, r_data0}, 32'hA534);

    // read-during-write
    wr(5, 16'h1111, 2'b11);
    step(1'b0, 1'b1, 5, 16'hBEEF, 2'b11, 1'b1, 5);
    chk("rdw_old", {16'b0, r_data0}, 32'h1111);
    chk("rdw_new", {16'b0, r_data1}, 32'hBEEF);
    rdq(5);
    chk("rdw_after", {16'b0, r_data0}, 32'hBEEF);
    wr(5, 16'h1111, 2'b11);
    step(1'b0, 1'b1, 5, 16'hBEEF, 2'b10, 1'b1, 5);
    chk("rdw_be10", {16'b0, r_data1}, 32'hBE11);

    // reset mid-operation with a read in flight
    wr(7, 16'h7777, 2'b11);
    rdq(7);
    step(1'b1, 1'b0, 0, '0, '0, 1'b1, 7);
    chk("rst_rdata", {16'b0, r_data0}, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 0, '0, '0, 1'b1, 7);
    rdq(7);
    chk("rst_cleared", {16'b0, r_data0}, 32'h0);

    // reset at sweep cycle 8 restarts a full sweep
    wr(9, 16'h9999, 2'b11);
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    for (int i = 0; i < 8; i++) idle();
    step(1'b1, 1'b0, 0, '0, '0, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) idle();
    rdq(9);
    chk("restart_cleared", {16'b0, r_data0}, 32'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), int'($urandom_range(0, DEPTH - 1)),
           DW'($urandom), NL'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
